// File: rtl/eeg_dct_pkg.sv
// Shared constants and types for the EEG window former and the DCT stages it feeds.
package eeg_dct_pkg;
  localparam int DCT_N      = 8;
  localparam int SAMPLE_W   = 8;
  localparam int DCT_CYCLES = 10;
  localparam int IDX_W      = $clog2(DCT_N);
  localparam int CNT_W      = $clog2(DCT_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} hold_state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/window_bank.sv
// One window of DCT_N signed samples: indexed write, all samples read in parallel.
module window_bank
  import eeg_dct_pkg::*;
(
  input  logic                       clk,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic signed [SAMPLE_W-1:0] wdata,
  output logic [DCT_N*SAMPLE_W-1:0]  rdata
);

  sample_t mem [DCT_N];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  for (genvar i = 0; i < DCT_N; i++) begin : g_rd
    assign rdata[i*SAMPLE_W +: SAMPLE_W] = mem[i];
  end

endmodule

// File: rtl/eeg_window_buffer.sv
// Ping-pong window former: fills one bank serially while the other is held
// stable for DCT_CYCLES cycles of en/cs, with a one-cycle gap between windows.
module eeg_window_buffer
  import eeg_dct_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  input  logic signed [SAMPLE_W-1:0] s_data,
  output logic                       s_ready,
  output logic signed [SAMPLE_W-1:0] input0,
  output logic signed [SAMPLE_W-1:0] input1,
  output logic signed [SAMPLE_W-1:0] input2,
  output logic signed [SAMPLE_W-1:0] input3,
  output logic signed [SAMPLE_W-1:0] input4,
  output logic signed [SAMPLE_W-1:0] input5,
  output logic signed [SAMPLE_W-1:0] input6,
  output logic signed [SAMPLE_W-1:0] input7,
  output logic                       en,
  output logic                       cs,
  output logic                       win_start
);

  logic [IDX_W-1:0]          wcnt;
  logic                      full;
  logic                      sel;       // index of the fill bank; hold bank is ~sel
  logic                      hold_vld;
  logic [CNT_W-1:0]          cnt;
  hold_state_t               state, state_nxt;
  logic                      accept, last_acc, swap;
  logic [DCT_N*SAMPLE_W-1:0] rd0, rd1, rd_hold;

  assign accept   = s_valid && !full;
  assign last_acc = accept && (wcnt == IDX_W'(DCT_N-1));

  window_bank u_bank0 (
    .clk   (clk),
    .we    (accept && !sel),
    .widx  (wcnt),
    .wdata (s_data),
    .rdata (rd0)
  );

  window_bank u_bank1 (
    .clk   (clk),
    .we    (accept && sel),
    .widx  (wcnt),
    .wdata (s_data),
    .rdata (rd1)
  );

  // A window completing on this very edge can start HOLD immediately.
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      IDLE: begin
        if (full || last_acc) begin
          state_nxt = HOLD;
          swap      = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) state_nxt = GAP;
      end
      GAP: begin
        if (full || last_acc) begin
          state_nxt = HOLD;
          swap      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      wcnt      <= '0;
      full      <= 1'b0;
      sel       <= 1'b0;
      hold_vld  <= 1'b0;
      win_start <= 1'b0;
    end else begin
      if (swap)                          cnt <= CNT_W'(DCT_CYCLES-1);
      else if (state == HOLD && cnt != '0) cnt <= cnt - CNT_W'(1);
      if (accept) wcnt <= wcnt + IDX_W'(1);
      if (swap)          full <= 1'b0;
      else if (last_acc) full <= 1'b1;
      if (swap) begin
        sel      <= ~sel;
        hold_vld <= 1'b1;
      end
      win_start <= swap;
    end
  end

  assign s_ready = !full;
  assign en      = (state == HOLD);
  assign cs      = en;
  assign rd_hold = sel ? rd0 : rd1;

  // Outputs read zero until the first window has been swapped in after reset.
  assign input0 = hold_vld ? rd_hold[0*SAMPLE_W +: SAMPLE_W] : '0;
  assign input1 = hold_vld ? rd_hold[1*SAMPLE_W +: SAMPLE_W] : '0;
  assign input2 = hold_vld ? rd_hold[2*SAMPLE_W +: SAMPLE_W] : '0;
  assign input3 = hold_vld ? rd_hold[3*SAMPLE_W +: SAMPLE_W] : '0;
  assign input4 = hold_vld ? rd_hold[4*SAMPLE_W +: SAMPLE_W] : '0;
  assign input5 = hold_vld ? rd_hold[5*SAMPLE_W +: SAMPLE_W] : '0;
  assign input6 = hold_vld ? rd_hold[6*SAMPLE_W +: SAMPLE_W] : '0;
  assign input7 = hold_vld ? rd_hold[7*SAMPLE_W +: SAMPLE_W] : '0;

endmodule
